// File: rtl/mcu_ctrl_rot_pkg.sv
// mcu_ctrl_rot_pkg: shared state encoding and pointer-width helper for the bank-ring controller
package mcu_ctrl_rot_pkg;
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        READY  = 2'd1,
        PROC   = 2'd2,
        REFILL = 2'd3
    } state_t;
    function automatic int clog2min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mcu_ring_ptr.sv
// mcu_ring_ptr: (base + off) mod BANKS with one-hot decode
//   base : current ring position, < BANKS
//   off  : offset, at most 2*BANKS so base + off < 3*BANKS
//   ptr  : reduced ring position
//   oh   : one-hot decode of ptr
module mcu_ring_ptr #(
    parameter int BANKS = 4,
    parameter int PW    = 2,
    parameter int XW    = 4
) (
    input  logic [PW-1:0]    base,
    input  logic [XW-1:0]    off,
    output logic [PW-1:0]    ptr,
    output logic [BANKS-1:0] oh
);
    localparam logic [XW-1:0] NB = XW'(BANKS);
    logic [XW-1:0] s0, s1, s2;
    // The sum stays below 3*BANKS, so two conditional subtractions fully reduce it.
    always_comb begin
        s0  = XW'(base) + off;
        s1  = (s0 >= NB) ? s0 - NB : s0;
        s2  = (s1 >= NB) ? s1 - NB : s1;
        ptr = s2[PW-1:0];
        oh  = BANKS'(1) << s2;
    end
endmodule

// File: rtl/mcu_ctrl_rot.sv
// mcu_ctrl_rot: bank-ring fill/process/refill sequencer for the convolution datapath
//   clk, rst (async, active-low)
//   i_chblk : block into the enabled bank complete (pulse)
//   i_sop   : convolver start request (level)
//   i_eop   : convolver finished current window (level)
//   i_last  : current window is the last of the frame (with i_eop)
//   o_we    : one-hot bank write enable or zero
//   o_state, o_substate, o_rd_base : FSM state, blocks loaded this phase, read-window base
//   o_done  : end-of-frame pulse; o_err : sticky protocol error
module mcu_ctrl_rot
    import mcu_ctrl_rot_pkg::*;
#(
    parameter int KERNEL = 3,
    parameter int STRIDE = 1,
    parameter int BANKS  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_chblk,
    input  logic                          i_sop,
    input  logic                          i_eop,
    input  logic                          i_last,
    output logic [BANKS-1:0]              o_we,
    output logic [1:0]                    o_state,
    output logic [$clog2(KERNEL+1)-1:0]   o_substate,
    output logic [clog2min1(BANKS)-1:0]   o_rd_base,
    output logic                          o_done,
    output logic                          o_err
);
    localparam int SW = $clog2(KERNEL + 1);
    localparam int PW = clog2min1(BANKS);
    localparam int XW = PW + 2;
    localparam bit PREFETCH = BANKS >= KERNEL + STRIDE;
    localparam logic [SW-1:0] K_LAST = SW'(KERNEL - 1);
    localparam logic [SW-1:0] S_FULL = SW'(STRIDE);
    localparam logic [SW-1:0] S_LAST = SW'(STRIDE - 1);
    state_t st;
    logic [SW-1:0] sub, sub_n;
    logic [PW-1:0] wp_base, wp_ptr, adv_ptr;
    logic [XW-1:0] wp_off;
    logic [BANKS-1:0] wp_oh, adv_oh;
    logic pf_ok, unused_ok;
    assign o_state    = st;
    assign o_substate = sub;
    always_comb begin
        pf_ok   = PREFETCH && (sub < S_FULL);
        // A chblk coincident with eop is counted before the eop is evaluated.
        sub_n   = (i_chblk && pf_ok) ? sub + 1'b1 : sub;
        wp_base = (st == FILL) ? '0 : o_rd_base;
        wp_off  = (st == FILL) ? XW'(sub) : XW'(KERNEL) + XW'(sub);
        o_we    = (st == FILL || st == REFILL || (st == PROC && pf_ok)) ? wp_oh : '0;
    end
    mcu_ring_ptr #(.BANKS(BANKS), .PW(PW), .XW(XW)) u_wp (
        .base(wp_base), .off(wp_off), .ptr(wp_ptr), .oh(wp_oh)
    );
    mcu_ring_ptr #(.BANKS(BANKS), .PW(PW), .XW(XW)) u_adv (
        .base(o_rd_base), .off(XW'(STRIDE)), .ptr(adv_ptr), .oh(adv_oh)
    );
    assign unused_ok = ^{wp_ptr, adv_oh};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= FILL;
            sub       <= '0;
            o_rd_base <= '0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (st)
                FILL: begin
                    if (i_sop) o_err <= 1'b1;
                    if (i_chblk) begin
                        sub <= (sub == K_LAST) ? '0 : sub + 1'b1;
                        if (sub == K_LAST) st <= READY;
                    end
                end
                READY: begin
                    if (i_chblk) o_err <= 1'b1;
                    if (i_sop) st <= PROC;
                end
                PROC: begin
                    if (i_chblk && !pf_ok) o_err <= 1'b1;
                    sub <= sub_n;
                    // Every eop leaves PROC, so it acts exactly once per entry.
                    if (i_eop) begin
                        if (i_last) begin
                            o_rd_base <= '0;
                            sub       <= '0;
                            o_done    <= 1'b1;
                            st        <= FILL;
                        end else if (sub_n == S_FULL) begin
                            o_rd_base <= adv_ptr;
                            sub       <= '0;
                            st        <= READY;
                        end else begin
                            st <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (i_sop) o_err <= 1'b1;
                    if (i_chblk) begin
                        sub <= (sub == S_LAST) ? '0 : sub + 1'b1;
                        if (sub == S_LAST) begin
                            o_rd_base <= adv_ptr;
                            st        <= READY;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mcu_ctrl_rot.sv
// tb_mcu_ctrl_rot: directed and randomized checks of three controller configurations
module tb_mcu_ctrl_rot;
    typedef struct {int st; int sub; int base; int err; int done;} mdl_t;
    int K[3] = '{3, 3, 3};
    int S[3] = '{1, 1, 2};
    int B[3] = '{4, 3, 5};
    mdl_t m[3];
    int checks = 0;
    int errors = 0;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic chb[3], sop[3], eop[3], lst[3], dn[3], er[3];
    logic [3:0] we0;
    logic [2:0] we1;
    logic [4:0] we2;
    logic [1:0] st0, st1, st2, sb0, sb1, sb2, bs0, bs1;
    logic [2:0] bs2;
    always #5 clk = ~clk;
    mcu_ctrl_rot #(.KERNEL(3), .STRIDE(1), .BANKS(4)) dut0 (
        .clk(clk), .rst(rst), .i_chblk(chb[0]), .i_sop(sop[0]), .i_eop(eop[0]), .i_last(lst[0]),
        .o_we(we0), .o_state(st0), .o_substate(sb0), .o_rd_base(bs0), .o_done(dn[0]), .o_err(er[0]));
    mcu_ctrl_rot #(.KERNEL(3), .STRIDE(1), .BANKS(3)) dut1 (
        .clk(clk), .rst(rst), .i_chblk(chb[1]), .i_sop(sop[1]), .i_eop(eop[1]), .i_last(lst[1]),
        .o_we(we1), .o_state(st1), .o_substate(sb1), .o_rd_base(bs1), .o_done(dn[1]), .o_err(er[1]));
    mcu_ctrl_rot #(.KERNEL(3), .STRIDE(2), .BANKS(5)) dut2 (
        .clk(clk), .rst(rst), .i_chblk(chb[2]), .i_sop(sop[2]), .i_eop(eop[2]), .i_last(lst[2]),
        .o_we(we2), .o_state(st2), .o_substate(sb2), .o_rd_base(bs2), .o_done(dn[2]), .o_err(er[2]));
    function automatic logic [31:0] we_of(input int d);
        return d == 0 ? 32'(we0) : d == 1 ? 32'(we1) : 32'(we2);
    endfunction
    function automatic logic [31:0] st_of(input int d);
        return d == 0 ? 32'(st0) : d == 1 ? 32'(st1) : 32'(st2);
    endfunction
    function automatic logic [31:0] sub_of(input int d);
        return d == 0 ? 32'(sb0) : d == 1 ? 32'(sb1) : 32'(sb2);
    endfunction
    function automatic logic [31:0] base_of(input int d);
        return d == 0 ? 32'(bs0) : d == 1 ? 32'(bs1) : 32'(bs2);
    endfunction
    // Reference behaviour: one clock edge with the given inputs.
    function automatic mdl_t step(input int d, input mdl_t x, input bit c, s, e, l);
        mdl_t y;
        bit pf;
        y = x;
        y.done = 0;
        pf = (B[d] >= K[d] + S[d]) && (x.sub < S[d]);
        if (x.st == 0) begin
            if (s) y.err = 1;
            if (c) begin
                y.sub = x.sub + 1;
                if (y.sub == K[d]) begin y.sub = 0; y.st = 1; end
            end
        end else if (x.st == 1) begin
            if (c) y.err = 1;
            if (s) y.st = 2;
        end else if (x.st == 2) begin
            if (c) begin
                if (pf) y.sub = x.sub + 1;
                else y.err = 1;
            end
            if (e) begin
                if (l) begin y.base = 0; y.sub = 0; y.done = 1; y.st = 0; end
                else if (y.sub == S[d]) begin y.base = (x.base + S[d]) % B[d]; y.sub = 0; y.st = 1; end
                else y.st = 3;
            end
        end else begin
            if (s) y.err = 1;
            if (c) begin
                y.sub = x.sub + 1;
                if (y.sub == S[d]) begin y.base = (x.base + S[d]) % B[d]; y.sub = 0; y.st = 1; end
            end
        end
        return y;
    endfunction
    function automatic int exp_we(input int d, input mdl_t x);
        int wp;
        bit en;
        wp = (x.st == 0) ? x.sub : (x.base + K[d] + x.sub) % B[d];
        en = x.st == 0 || x.st == 3 || (x.st == 2 && B[d] >= K[d] + S[d] && x.sub < S[d]);
        return en ? (1 << wp) : 0;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 0};
    endtask
    task automatic tick(input int d, input bit c, s, e, l);
        @(negedge clk);
        chb[d] = c; sop[d] = s; eop[d] = e; lst[d] = l;
        @(posedge clk);
        for (int i = 0; i < 3; i++) m[i] = step(i, m[i], chb[i], sop[i], eop[i], lst[i]);
        #1;
        chb[d] = 0; sop[d] = 0; eop[d] = 0; lst[d] = 0;
    endtask
    task automatic fill(input int d);
        repeat (3) tick(d, 1, 0, 0, 0);
    endtask
    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (st_of(i) !== 0 || sub_of(i) !== 0 || base_of(i) !== 0 || we_of(i) !== 1 || dn[i] !== 1'b0 || er[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d got st=%0d sub=%0d base=%0d we=%0h done=%b err=%b exp 0/0/0/1/0/0",
                         i, st_of(i), sub_of(i), base_of(i), we_of(i), dn[i], er[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask
    task automatic test_fill();
        int exp_w[3] = '{2, 4, 0};
        for (int k = 0; k < 3; k++) begin
            tick(0, 1, 0, 0, 0);
            checks++;
            if (we_of(0) !== exp_w[k]) begin
                errors++;
                $display("FAIL fill_we step%0d got=%0h exp=%0h", k, we_of(0), exp_w[k]);
            end
        end
        checks++;
        if (st_of(0) !== 1 || sub_of(0) !== 0) begin
            errors++;
            $display("FAIL fill_done got st=%0d sub=%0d exp st=1 sub=0", st_of(0), sub_of(0));
        end
    endtask
    task automatic test_prefetch();
        tick(0, 0, 1, 0, 0);
        checks++;
        if (st_of(0) !== 2 || we_of(0) !== 8) begin
            errors++;
            $display("FAIL proc_entry got st=%0d we=%0h exp st=2 we=8", st_of(0), we_of(0));
        end
        tick(0, 1, 0, 0, 0);
        checks++;
        if (sub_of(0) !== 1 || we_of(0) !== 0 || er[0] !== 1'b0) begin
            errors++;
            $display("FAIL prefetch got sub=%0d we=%0h err=%b exp sub=1 we=0 err=0", sub_of(0), we_of(0), er[0]);
        end
        tick(0, 0, 0, 1, 0);
        checks++;
        if (base_of(0) !== 1 || st_of(0) !== 1 || sub_of(0) !== 0) begin
            errors++;
            $display("FAIL prefetch_eop got base=%0d st=%0d sub=%0d exp base=1 st=1 sub=0", base_of(0), st_of(0), sub_of(0));
        end
    endtask
    task automatic test_last();
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 1, 1);
        checks++;
        if (dn[0] !== 1'b1 || base_of(0) !== 0 || st_of(0) !== 0 || we_of(0) !== 1) begin
            errors++;
            $display("FAIL last got done=%b base=%0d st=%0d we=%0h exp done=1 base=0 st=0 we=1", dn[0], base_of(0), st_of(0), we_of(0));
        end
        tick(0, 0, 0, 0, 0);
        checks++;
        if (dn[0] !== 1'b0) begin
            errors++;
            $display("FAIL done_width got done=%b exp 0", dn[0]);
        end
    endtask
    task automatic test_no_prefetch();
        fill(1);
        tick(1, 0, 1, 0, 0);
        checks++;
        if (we_of(1) !== 0) begin
            errors++;
            $display("FAIL nopf_we got=%0h exp=0", we_of(1));
        end
        tick(1, 1, 0, 0, 0);
        checks++;
        if (er[1] !== 1'b1 || sub_of(1) !== 0 || st_of(1) !== 2) begin
            errors++;
            $display("FAIL nopf_err got err=%b sub=%0d st=%0d exp err=1 sub=0 st=2", er[1], sub_of(1), st_of(1));
        end
        tick(1, 0, 0, 1, 0);
        checks++;
        if (st_of(1) !== 3 || we_of(1) !== 1) begin
            errors++;
            $display("FAIL nopf_refill got st=%0d we=%0h exp st=3 we=1", st_of(1), we_of(1));
        end
        tick(1, 1, 0, 0, 0);
        checks++;
        if (base_of(1) !== 1 || st_of(1) !== 1) begin
            errors++;
            $display("FAIL nopf_adv got base=%0d st=%0d exp base=1 st=1", base_of(1), st_of(1));
        end
    endtask
    task automatic test_wrap();
        int exp_b[3] = '{2, 4, 1};
        fill(2);
        for (int k = 0; k < 3; k++) begin
            tick(2, 0, 1, 0, 0);
            tick(2, 1, 0, 0, 0);
            tick(2, 1, 0, 0, 0);
            tick(2, 0, 0, 1, 0);
            checks++;
            if (base_of(2) !== exp_b[k] || st_of(2) !== 1) begin
                errors++;
                $display("FAIL wrap step%0d got base=%0d st=%0d exp base=%0d st=1", k, base_of(2), st_of(2), exp_b[k]);
            end
        end
    endtask
    task automatic test_back_to_back();
        fill(0);
        tick(0, 0, 1, 0, 0);
        tick(0, 1, 0, 1, 0);
        checks++;
        if (st_of(0) !== 1 || base_of(0) !== 1 || sub_of(0) !== 0 || er[0] !== 1'b0) begin
            errors++;
            $display("FAIL chblk_eop got st=%0d base=%0d sub=%0d err=%b exp st=1 base=1 sub=0 err=0", st_of(0), base_of(0), sub_of(0), er[0]);
        end
        tick(0, 1, 0, 0, 0);
        checks++;
        if (er[0] !== 1'b1) begin
            errors++;
            $display("FAIL ready_chblk_err got err=%b exp 1", er[0]);
        end
    endtask
    task automatic test_async_reset();
        tick(1, 0, 1, 0, 0);
        tick(1, 0, 0, 1, 0);
        checks++;
        if (st_of(1) !== 3) begin
            errors++;
            $display("FAIL pre_reset_refill got st=%0d exp 3", st_of(1));
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (st_of(1) !== 0 || sub_of(1) !== 0 || base_of(1) !== 0 || we_of(1) !== 1 || dn[1] !== 1'b0 || er[1] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got st=%0d sub=%0d base=%0d we=%0h done=%b err=%b exp 0/0/0/1/0/0",
                     st_of(1), sub_of(1), base_of(1), we_of(1), dn[1], er[1]);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask
    task automatic test_random();
        repeat (400) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chb[i] = ($urandom_range(0, 1) == 0);
                sop[i] = (m[i].st == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 40) == 0);
                eop[i] = ($urandom_range(0, 3) == 0);
                lst[i] = ($urandom_range(0, 7) == 0);
            end
            @(posedge clk);
            for (int i = 0; i < 3; i++) m[i] = step(i, m[i], chb[i], sop[i], eop[i], lst[i]);
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (st_of(i) !== m[i].st || sub_of(i) !== m[i].sub || base_of(i) !== m[i].base ||
                    we_of(i) !== exp_we(i, m[i]) || dn[i] !== m[i].done[0] || er[i] !== m[i].err[0]) begin
                    errors++;
                    $display("FAIL random dut%0d got st=%0d sub=%0d base=%0d we=%0h done=%b err=%b exp st=%0d sub=%0d base=%0d we=%0h done=%0d err=%0d",
                             i, st_of(i), sub_of(i), base_of(i), we_of(i), dn[i], er[i],
                             m[i].st, m[i].sub, m[i].base, exp_we(i, m[i]), m[i].done, m[i].err);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            chb[i] = 0; sop[i] = 0; eop[i] = 0; lst[i] = 0;
        end
    endtask
    initial begin
        for (int i = 0; i < 3; i++) begin
            chb[i] = 0; sop[i] = 0; eop[i] = 0; lst[i] = 0;
        end
        test_reset();
        test_fill();
        test_prefetch();
        test_last();
        test_no_prefetch();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mcu_ctrl_rot.md
# mcu_ctrl_rot

Parametrised memory-control-unit controller for the 2D convolution datapath. It sequences a ring of BANKS block memories: it fills KERNEL banks, hands the read window to the convolver, and refills STRIDE banks per step with a rotating base pointer. When spare banks exist, it optionally prefetches during processing. It sits between the input block streamer (`i_chblk`) and the convolver (`i_sop`/`i_eop`), driving bank write enables and the read-window base.

## Interface

Parameters:
- KERNEL, 3, kernel width in columns (banks read per window), ≥1.
- STRIDE, 1, banks replaced per step, 1..KERNEL.
- BANKS, 4, physical banks, ≥KERNEL. Prefetch enabled iff BANKS ≥ KERNEL+STRIDE (localparam PREFETCH).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_chblk  in  1  one-cycle pulse: block currently written to the enabled bank is complete.
- i_sop  in  1  level: convolver start request.
- i_eop  in  1  level: convolver finished the current window.
- i_last  in  1  sampled with the i_eop edge: this window is the last of the frame.
- o_we  out  BANKS  one-hot bank write enable, or zero.
- o_state  out  2  FILL=0, READY=1, PROC=2, REFILL=3.
- o_substate  out  $clog2(KERNEL+1)  blocks loaded in the current fill/refill phase.
- o_rd_base  out  max(1,$clog2(BANKS))  first bank of the read window.
- o_done  out  1  one-cycle pulse at end of frame.
- o_err  out  1  sticky protocol-error flag.

## Operation

- Write pointer wp = (o_rd_base + KERNEL + o_substate) mod BANKS. In FILL, wp = o_substate.
- o_we is combinational: onehot(wp) in FILL and REFILL. In PROC it is onehot(wp) if PREFETCH and o_substate < STRIDE. It is 0 otherwise.
- FILL: each i_chblk increments o_substate. When the count reaches KERNEL: o_substate←0, go to READY.
- READY: on i_sop=1, go to PROC.
- PROC, on i_chblk:
  - if the prefetch condition holds, increment o_substate;
  - else set o_err and make no other change.
- PROC, on first i_eop=1:
  - if i_last: o_rd_base←0, o_substate←0, o_done pulse, go to FILL;
  - else if o_substate==STRIDE: o_rd_base←(o_rd_base+STRIDE) mod BANKS, o_substate←0, go to READY;
  - else go to REFILL (o_substate kept).
- REFILL: each i_chblk increments o_substate. At STRIDE: advance o_rd_base as above, o_substate←0, go to READY.
- Errors set o_err (held until reset):
  - i_chblk in READY;
  - i_sop=1 in FILL or REFILL.
- The offending event is otherwise ignored.
- Simultaneous i_chblk and i_eop in PROC: count the chblk first, then evaluate the eop with the updated count.
- Modulo arithmetic uses explicit compare-and-subtract. BANKS need not be a power of two.

## Timing

- Reset values (async assert, sync release): o_state=FILL, o_substate=0, o_rd_base=0, o_done=0, o_err=0. o_we=onehot(0) because of the FILL decode.
- All state, counter and pointer updates occur at the clk edge that samples the event. o_we reflects the new wp the following cycle.
- i_eop is level-sensitive but acts once per PROC entry. It is ignored outside PROC.
- i_sop must be held high for at least one cycle while in READY.
- o_done is high for exactly the one cycle after the eop edge that ended the frame.
- READY→PROC has 1 cycle of latency from i_sop. With a completed prefetch, PROC→READY takes 1 cycle.

## Structure

- Shared package: state encoding constants (FILL/READY/PROC/REFILL) and a width helper clog2min1.
- One sub-module, mcu_ring_ptr: mod-BANKS adder (base + offset) with one-hot decode, reused for wp and the o_rd_base advance.
- The FSM plus counters stay in mcu_ctrl_rot.

## Test plan

- K3/S1/B4: reset, 3 chblk pulses. Required: o_we 0001→0010→0100, then o_state=READY, o_substate=0.
- Same config: i_sop, one chblk during PROC (o_we=1000), then eop. Required: o_rd_base=1, o_state=READY, no REFILL cycle.
- K3/S1/B3 (no prefetch): chblk in PROC sets o_err. Then eop goes to REFILL with o_we=001, chblk gives o_rd_base=1.
- Wrap-around, K3/S2/B5: run three steps. Required: o_rd_base 0→2→4→1.
- i_last with eop. Required: o_done one-cycle pulse, o_rd_base=0, o_state=FILL, o_we=0001.
- Assert rst mid-REFILL. Required: all outputs return to reset values immediately, without waiting for clk.
